// File: rtl/key_debounce.sv
// Multi-channel push-button conditioner: two-flop synchroniser plus a per-channel
// hold-time filter FSM producing registered press/release pulses and a debounced level.
module key_debounce #(
    parameter int KEY_W   = 1,
    parameter int CNT_MAX = 999_999,
    parameter int CNT_W   = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_flag,
    output logic [KEY_W-1:0] key_release,
    output logic [KEY_W-1:0] key_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        DOWN    = 2'd2,
        FILT_UP = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    for (genvar g = 0; g < KEY_W; g++) begin : g_ch
        logic             sync_p0;
        logic             key_s_p1;
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             flag_r;
        logic             rel_r;
        logic             level_r;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync_p0  <= 1'b1;
                key_s_p1 <= 1'b1;
                state    <= IDLE;
                cnt      <= '0;
                flag_r   <= 1'b0;
                rel_r    <= 1'b0;
                level_r  <= 1'b1;
            end else begin
                // synchroniser stage boundary: key_in -> sync_p0 -> key_s_p1
                sync_p0  <= key_in[g];
                key_s_p1 <= sync_p0;
                flag_r   <= 1'b0;
                rel_r    <= 1'b0;
                cnt      <= '0;
                case (state)
                    IDLE: begin
                        if (!key_s_p1)
                            state <= FILT_DN;
                    end
                    FILT_DN: begin
                        if (key_s_p1) begin
                            state <= IDLE;
                        end else if (cnt == CNT_LAST) begin
                            state   <= DOWN;
                            flag_r  <= 1'b1;
                            level_r <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    DOWN: begin
                        if (key_s_p1)
                            state <= FILT_UP;
                    end
                    FILT_UP: begin
                        if (!key_s_p1) begin
                            state <= DOWN;
                        end else if (cnt == CNT_LAST) begin
                            state   <= IDLE;
                            rel_r   <= 1'b1;
                            level_r <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign key_flag[g]    = flag_r;
        assign key_release[g] = rel_r;
        assign key_state[g]   = level_r;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (KEY_W=4, CNT_MAX=9): table of held-input segments
// with expected outputs after every edge, plus bounded latency sequences.
module tb_key_debounce;

    localparam int KEY_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [KEY_W-1:0] key_in = 4'hF;
    logic [KEY_W-1:0] key_flag;
    logic [KEY_W-1:0] key_release;
    logic [KEY_W-1:0] key_state;

    int total = 0;
    int bad   = 0;

    key_debounce #(
        .KEY_W  (KEY_W),
        .CNT_MAX(9),
        .CNT_W  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_flag   (key_flag),
        .key_release(key_release),
        .key_state  (key_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] key;
        int         n;
        logic [3:0] flag;
        logic [3:0] rel;
        logic [3:0] st;
        string      name;
    } seg_t;

    seg_t tbl[$];

    function automatic void add(input logic rst, input logic [3:0] key, input int n,
                                input logic [3:0] flag, input logic [3:0] rel,
                                input logic [3:0] st, input string name);
        seg_t s;
        s.rst = rst; s.key = key; s.n = n; s.flag = flag; s.rel = rel; s.st = st; s.name = name;
        tbl.push_back(s);
    endfunction

    task automatic check(input string name, input logic [3:0] f, input logic [3:0] r,
                         input logic [3:0] s);
        total++;
        if (key_flag !== f || key_release !== r || key_state !== s) begin
            bad++;
            $display("FAIL %s: got flag=%b rel=%b state=%b, want flag=%b rel=%b state=%b",
                     name, key_flag, key_release, key_state, f, r, s);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        bit seen;

        // reset with buttons released, then reset held with ch0 pressed
        add(0, 4'b1111, 3,  4'b0000, 4'b0000, 4'b1111, "reset_idle");
        add(0, 4'b1110, 3,  4'b0000, 4'b0000, 4'b1111, "reset_held_key");
        add(1, 4'b1110, 12, 4'b0000, 4'b0000, 4'b1111, "post_reset_filter");
        add(1, 4'b1110, 1,  4'b0001, 4'b0000, 4'b1110, "post_reset_flag");
        add(1, 4'b1110, 3,  4'b0000, 4'b0000, 4'b1110, "post_reset_down");
        add(1, 4'b1111, 12, 4'b0000, 4'b0000, 4'b1110, "release0_filter");
        add(1, 4'b1111, 1,  4'b0000, 4'b0001, 4'b1111, "release0_pulse");
        add(1, 4'b1111, 3,  4'b0000, 4'b0000, 4'b1111, "release0_idle");
        // clean press held 30 cycles then released
        add(1, 4'b1110, 12, 4'b0000, 4'b0000, 4'b1111, "clean_filter");
        add(1, 4'b1110, 1,  4'b0001, 4'b0000, 4'b1110, "clean_flag");
        add(1, 4'b1110, 17, 4'b0000, 4'b0000, 4'b1110, "clean_hold");
        add(1, 4'b1111, 12, 4'b0000, 4'b0000, 4'b1110, "clean_rel_filter");
        add(1, 4'b1111, 1,  4'b0000, 4'b0001, 4'b1111, "clean_rel_pulse");
        add(1, 4'b1111, 5,  4'b0000, 4'b0000, 4'b1111, "clean_idle");
        // bounce: low 5, high 2, low 20 -> one flag 13 edges after the final fall
        add(1, 4'b1110, 5,  4'b0000, 4'b0000, 4'b1111, "bounce_low1");
        add(1, 4'b1111, 2,  4'b0000, 4'b0000, 4'b1111, "bounce_high");
        add(1, 4'b1110, 12, 4'b0000, 4'b0000, 4'b1111, "bounce_refilter");
        add(1, 4'b1110, 1,  4'b0001, 4'b0000, 4'b1110, "bounce_flag");
        add(1, 4'b1110, 7,  4'b0000, 4'b0000, 4'b1110, "bounce_down");
        // release glitch of 4 cycles while pressed
        add(1, 4'b1111, 4,  4'b0000, 4'b0000, 4'b1110, "glitch_high");
        add(1, 4'b1110, 20, 4'b0000, 4'b0000, 4'b1110, "glitch_down");
        add(1, 4'b1111, 12, 4'b0000, 4'b0000, 4'b1110, "glitch_rel_filter");
        add(1, 4'b1111, 1,  4'b0000, 4'b0001, 4'b1111, "glitch_rel_pulse");
        add(1, 4'b1111, 3,  4'b0000, 4'b0000, 4'b1111, "glitch_idle");
        // reset while FILT_DN has cnt = 6, then requalify from scratch
        add(1, 4'b1110, 9,  4'b0000, 4'b0000, 4'b1111, "midrst_filter");
        add(0, 4'b1110, 2,  4'b0000, 4'b0000, 4'b1111, "midrst_reset");
        add(1, 4'b1110, 12, 4'b0000, 4'b0000, 4'b1111, "midrst_requal");
        add(1, 4'b1110, 1,  4'b0001, 4'b0000, 4'b1110, "midrst_flag");
        add(1, 4'b1111, 12, 4'b0000, 4'b0000, 4'b1110, "midrst_rel_filter");
        add(1, 4'b1111, 1,  4'b0000, 4'b0001, 4'b1111, "midrst_rel_pulse");
        add(1, 4'b1111, 3,  4'b0000, 4'b0000, 4'b1111, "midrst_idle");
        // multi-channel: ch0+ch2 together, ch3 five cycles later, ch1 untouched
        add(1, 4'b1010, 5,  4'b0000, 4'b0000, 4'b1111, "multi_first");
        add(1, 4'b0010, 7,  4'b0000, 4'b0000, 4'b1111, "multi_second");
        add(1, 4'b0010, 1,  4'b0101, 4'b0000, 4'b1010, "multi_flag02");
        add(1, 4'b0010, 4,  4'b0000, 4'b0000, 4'b1010, "multi_gap");
        add(1, 4'b0010, 1,  4'b1000, 4'b0000, 4'b0010, "multi_flag3");
        add(1, 4'b0010, 5,  4'b0000, 4'b0000, 4'b0010, "multi_down");
        add(1, 4'b1111, 12, 4'b0000, 4'b0000, 4'b0010, "multi_rel_filter");
        add(1, 4'b1111, 1,  4'b0000, 4'b1101, 4'b1111, "multi_rel_pulse");
        add(1, 4'b1111, 3,  4'b0000, 4'b0000, 4'b1111, "multi_idle");

        foreach (tbl[i]) begin
            rst_n  = tbl[i].rst;
            key_in = tbl[i].key;
            for (int c = 0; c < tbl[i].n; c++) begin
                tick();
                check(tbl[i].name, tbl[i].flag, tbl[i].rel, tbl[i].st);
            end
        end

        // channel 1 press latency measured with a bounded wait
        key_in = 4'b1101;
        lat = 0;
        seen = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            tick();
            if (key_flag[1]) begin
                seen = 1;
                lat = c;
            end
        end
        total++;
        if (!seen || lat != 13) begin
            bad++;
            $display("FAIL ch1_press_latency: got %0d (seen=%0d), want 13", lat, seen);
        end
        tick();
        check("ch1_flag_one_cycle", 4'b0000, 4'b0000, 4'b1101);

        // channel 1 release latency, key_state must stay 0 until the pulse
        key_in = 4'b1111;
        lat = 0;
        seen = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            tick();
            if (key_release[1]) begin
                seen = 1;
                lat = c;
            end else begin
                total++;
                if (key_state[1] !== 1'b0 || key_flag !== 4'b0000) begin
                    bad++;
                    $display("FAIL ch1_hold_level: got state=%b flag=%b, want state[1]=0 flag=0000",
                             key_state, key_flag);
                end
            end
        end
        total++;
        if (!seen || lat != 13) begin
            bad++;
            $display("FAIL ch1_release_latency: got %0d (seen=%0d), want 13", lat, seen);
        end
        check("ch1_release_state", 4'b0000, 4'b0010, 4'b1111);
        tick();
        check("ch1_release_done", 4'b0000, 4'b0000, 4'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
